// File: rtl/ex_stage.sv
// Execute stage: ALU operand selection, 16-op ALU, branch/jump resolution,
// and a one-entry EX/MEM register with a valid/ready handshake towards MEM
// plus a registered one-cycle redirect pulse towards fetch.
module ex_stage #(
    parameter int DATA_LEN = 64,
    parameter int REG_AW   = 5
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_LEN-1:0] pc_i,
    input  logic [DATA_LEN-1:0] rs1_i,
    input  logic [DATA_LEN-1:0] rs2_i,
    input  logic [DATA_LEN-1:0] imm_i,
    input  logic [3:0]          alu_op_i,
    input  logic [1:0]          a_sel_i,
    input  logic [1:0]          b_sel_i,
    input  logic                br_en_i,
    input  logic [2:0]          funct3_i,
    input  logic                jal_i,
    input  logic                jalr_i,
    input  logic                mem_rd_i,
    input  logic                mem_wr_i,
    input  logic [REG_AW-1:0]   rd_i,
    input  logic                rd_wen_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_LEN-1:0] result_o,
    output logic [DATA_LEN-1:0] store_data_o,
    output logic [2:0]          funct3_o,
    output logic                mem_rd_o,
    output logic                mem_wr_o,
    output logic [REG_AW-1:0]   rd_o,
    output logic                rd_wen_o,
    output logic                redirect_o,
    output logic [DATA_LEN-1:0] redirect_pc_o,
    output logic                misalign_o
);

    localparam int SH_W = $clog2(DATA_LEN);
    localparam int HALF = DATA_LEN / 2;
    localparam logic [DATA_LEN-1:0] CONST4 = DATA_LEN'(4);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_OR   = 4'd2,  OP_AND  = 4'd3,
        OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_COPY = 4'd10, OP_ADDW = 4'd11,
        OP_SUBW = 4'd12, OP_SLLW = 4'd13, OP_SRLW = 4'd14, OP_SRAW = 4'd15
    } alu_op_e;

    logic [DATA_LEN-1:0] a_op, b_op, alu_res, target, jalr_sum, pc_plus4;
    logic [HALF-1:0]     w_res;
    logic                use_w, br_cond, taken, fire;

    logic                out_valid_q, out_valid_d;
    logic [DATA_LEN-1:0] result_q, result_d;
    logic [DATA_LEN-1:0] store_data_q, store_data_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic                rd_wen_q, rd_wen_d;
    logic                redirect_q, redirect_d;
    logic [DATA_LEN-1:0] redirect_pc_q, redirect_pc_d;
    logic                misalign_q, misalign_d;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign fire       = in_valid_i && in_ready_o && !flush_i;

    // Operand muxes: A from rs1/pc/zero, B from rs2/imm/const 4.
    always_comb begin
        unique case (a_sel_i)
            2'd0:    a_op = rs1_i;
            2'd1:    a_op = pc_i;
            default: a_op = '0;
        endcase
        unique case (b_sel_i)
            2'd0:    b_op = rs2_i;
            2'd2:    b_op = CONST4;
            default: b_op = imm_i;
        endcase
    end

    // ALU: full-width ops directly, W-ops on the low half then sign-extended.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        alu_res = '0;
        w_res   = '0;
        use_w   = 1'b0;
        unique case (alu_op_e'(alu_op_i))
            OP_ADD:  alu_res = a_op + b_op;
            OP_SUB:  alu_res = a_op - b_op;
            OP_OR:   alu_res = a_op | b_op;
            OP_AND:  alu_res = a_op & b_op;
            OP_XOR:  alu_res = a_op ^ b_op;
            OP_SLL:  alu_res = a_op << b_op[SH_W-1:0];
            OP_SRL:  alu_res = a_op >> b_op[SH_W-1:0];
            OP_SRA:  alu_res = $signed(a_op) >>> b_op[SH_W-1:0];
            OP_SLT:  alu_res = {{(DATA_LEN-1){1'b0}}, $signed(a_op) < $signed(b_op)};
            OP_SLTU: alu_res = {{(DATA_LEN-1){1'b0}}, a_op < b_op};
            OP_COPY: alu_res = b_op;
            OP_ADDW: begin use_w = 1'b1; w_res = a_op[HALF-1:0] + b_op[HALF-1:0]; end
            OP_SUBW: begin use_w = 1'b1; w_res = a_op[HALF-1:0] - b_op[HALF-1:0]; end
            OP_SLLW: begin use_w = 1'b1; w_res = a_op[HALF-1:0] << b_op[SH_W-2:0]; end
            OP_SRLW: begin use_w = 1'b1; w_res = a_op[HALF-1:0] >> b_op[SH_W-2:0]; end
            OP_SRAW: begin use_w = 1'b1; w_res = $signed(a_op[HALF-1:0]) >>> b_op[SH_W-2:0]; end
            default: alu_res = '0;
        endcase
        if (use_w) alu_res = {{HALF{w_res[HALF-1]}}, w_res};
    end

    // Branch condition always compares rs1 against rs2, whatever the operand muxes select.
    always_comb begin
        unique case (funct3_i)
            3'b000:  br_cond = rs1_i == rs2_i;
            3'b001:  br_cond = rs1_i != rs2_i;
            3'b100:  br_cond = $signed(rs1_i) <  $signed(rs2_i);
            3'b101:  br_cond = $signed(rs1_i) >= $signed(rs2_i);
            3'b110:  br_cond = rs1_i <  rs2_i;
            3'b111:  br_cond = rs1_i >= rs2_i;
            default: br_cond = 1'b0;
        endcase
        taken    = jal_i || jalr_i || (br_en_i && br_cond);
        jalr_sum = rs1_i + imm_i;
        target   = jalr_i ? {jalr_sum[DATA_LEN-1:1], 1'b0} : pc_i + imm_i;
        pc_plus4 = pc_i + CONST4;
    end

    // Next state of the EX/MEM register: load on fire, drain on ready, drop on flush.
    always_comb begin
        out_valid_d   = out_valid_q;
        result_d      = result_q;
        store_data_d  = store_data_q;
        funct3_d      = funct3_q;
        mem_rd_d      = mem_rd_q;
        mem_wr_d      = mem_wr_q;
        rd_d          = rd_q;
        rd_wen_d      = rd_wen_q;
        redirect_pc_d = redirect_pc_q;
        misalign_d    = misalign_q;
        // Redirect is a pulse tied to fire, so a stalled entry never repeats it.
        redirect_d    = fire && taken;

        if (flush_i)          out_valid_d = 1'b0;
        else if (fire)        out_valid_d = 1'b1;
        else if (out_ready_i) out_valid_d = 1'b0;

        if (fire) begin
            result_d      = (jal_i || jalr_i) ? pc_plus4 : alu_res;
            store_data_d  = rs2_i;
            funct3_d      = funct3_i;
            mem_rd_d      = mem_rd_i;
            mem_wr_d      = mem_wr_i;
            rd_d          = rd_i;
            rd_wen_d      = rd_wen_i;
            redirect_pc_d = target;
            misalign_d    = taken && target[1];
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            store_data_q  <= '0;
            funct3_q      <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            rd_q          <= '0;
            rd_wen_q      <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            store_data_q  <= store_data_d;
            funct3_q      <= funct3_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            rd_q          <= rd_d;
            rd_wen_q      <= rd_wen_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            misalign_q    <= misalign_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign result_o      = result_q;
    assign store_data_o  = store_data_q;
    assign funct3_o      = funct3_q;
    assign mem_rd_o      = mem_rd_q;
    assign mem_wr_o      = mem_wr_q;
    assign rd_o          = rd_q;
    assign rd_wen_o      = rd_wen_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios followed by random traffic, all
// checked against a behavioural model of the execute stage.
module tb_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i, in_valid_i, in_ready_o;
    logic [63:0] pc_i, rs1_i, rs2_i, imm_i;
    logic [3:0]  alu_op_i;
    logic [1:0]  a_sel_i, b_sel_i;
    logic        br_en_i, jal_i, jalr_i, mem_rd_i, mem_wr_i, rd_wen_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic        out_valid_o, out_ready_i;
    logic [63:0] result_o, store_data_o, redirect_pc_o;
    logic [2:0]  funct3_o;
    logic        mem_rd_o, mem_wr_o, rd_wen_o, redirect_o, misalign_o;
    logic [4:0]  rd_o;

    int errors = 0;
    int checks = 0;

    // Model of the EX/MEM register contents.
    logic        m_valid, m_redirect, m_mis, m_mrd, m_mwr, m_wen;
    logic [63:0] m_result, m_store, m_rpc;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    logic [63:0] held;

    ex_stage #(.DATA_LEN(64), .REG_AW(5)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .alu_op_i(alu_op_i), .a_sel_i(a_sel_i), .b_sel_i(b_sel_i),
        .br_en_i(br_en_i), .funct3_i(funct3_i), .jal_i(jal_i), .jalr_i(jalr_i),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .rd_i(rd_i), .rd_wen_i(rd_wen_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .store_data_o(store_data_o), .funct3_o(funct3_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .rd_o(rd_o), .rd_wen_o(rd_wen_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU written from the op table using native signed/unsigned arithmetic.
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int sh6, sh5;
        sh6 = int'(b[5:0]);
        sh5 = int'(b[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a | b;
            4'd3:  return a & b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh6;
            4'd6:  return a >> sh6;
            4'd7:  return longint'(a) >>> sh6;
            4'd8:  return (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
            4'd9:  return (a < b) ? 64'd1 : 64'd0;
            4'd10: return b;
            4'd11: return longint'(int'(a[31:0] + b[31:0]));
            4'd12: return longint'(int'(a[31:0] - b[31:0]));
            4'd13: return longint'(int'(a[31:0] << sh5));
            4'd14: return longint'(int'(a[31:0] >> sh5));
            default: return longint'(int'(a[31:0]) >>> sh5);
        endcase
    endfunction

    function automatic logic ref_branch(input logic [2:0] f3, input logic [63:0] x, input logic [63:0] y);
        case (f3)
            3'b000: return x == y;
            3'b001: return x != y;
            3'b100: return longint'(x) <  longint'(y);
            3'b101: return longint'(x) >= longint'(y);
            3'b110: return x < y;
            3'b111: return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_redirect = 0; m_mis = 0; m_mrd = 0; m_mwr = 0; m_wen = 0;
        m_result = '0; m_store = '0; m_rpc = '0; m_f3 = '0; m_rd = '0;
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".out_valid"}, 64'(out_valid_o), 64'(m_valid));
        check({ctx, ".redirect"},  64'(redirect_o),  64'(m_redirect));
        if (m_valid) begin
            check({ctx, ".result"},   result_o,          m_result);
            check({ctx, ".store"},    store_data_o,      m_store);
            check({ctx, ".funct3"},   64'(funct3_o),     64'(m_f3));
            check({ctx, ".mem_rd"},   64'(mem_rd_o),     64'(m_mrd));
            check({ctx, ".mem_wr"},   64'(mem_wr_o),     64'(m_mwr));
            check({ctx, ".rd"},       64'(rd_o),         64'(m_rd));
            check({ctx, ".rd_wen"},   64'(rd_wen_o),     64'(m_wen));
            check({ctx, ".misalign"}, 64'(misalign_o),   64'(m_mis));
        end
        if (m_redirect) check({ctx, ".redirect_pc"}, redirect_pc_o, m_rpc);
    endtask

    // One clock: check ready, advance the model from current inputs, then check outputs after the edge.
    task automatic cyc(input string ctx);
        logic        rdy, fire, tk;
        logic [63:0] a, b, tgt;
        #1;
        rdy = !m_valid || out_ready_i;
        check({ctx, ".in_ready"}, 64'(in_ready_o), 64'(rdy));
        fire = in_valid_i && rdy && !flush_i;
        a = (a_sel_i == 2'd0) ? rs1_i : (a_sel_i == 2'd1) ? pc_i : 64'd0;
        b = (b_sel_i == 2'd0) ? rs2_i : (b_sel_i == 2'd2) ? 64'd4 : imm_i;
        tk  = jal_i || jalr_i || (br_en_i && ref_branch(funct3_i, rs1_i, rs2_i));
        tgt = jalr_i ? ((rs1_i + imm_i) & ~64'd1) : (pc_i + imm_i);
        if (flush_i)          m_valid = 0;
        else if (fire)        m_valid = 1;
        else if (out_ready_i) m_valid = 0;
        m_redirect = fire && tk;
        if (fire) begin
            m_result = (jal_i || jalr_i) ? pc_i + 64'd4 : ref_alu(alu_op_i, a, b);
            m_store  = rs2_i;
            m_f3 = funct3_i; m_mrd = mem_rd_i; m_mwr = mem_wr_i;
            m_rd = rd_i; m_wen = rd_wen_i;
            m_rpc = tgt; m_mis = tk && tgt[1];
        end
        @(posedge clk_i);
        #1;
        check_outputs(ctx);
    endtask

    // kind: 0 plain ALU, 1 branch, 2 jal, 3 jalr
    task automatic bundle(input logic [3:0] op, input logic [1:0] as, input logic [1:0] bs,
                          input logic [63:0] pc, input logic [63:0] r1, input logic [63:0] r2,
                          input logic [63:0] imm, input int kind, input logic [2:0] f3);
        in_valid_i = 1; alu_op_i = op; a_sel_i = as; b_sel_i = bs;
        pc_i = pc; rs1_i = r1; rs2_i = r2; imm_i = imm; funct3_i = f3;
        br_en_i = (kind == 1); jal_i = (kind == 2); jalr_i = (kind == 3);
        mem_rd_i = 0; mem_wr_i = 0; rd_i = 5'd1; rd_wen_i = 1;
    endtask

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h0000_0000_8000_0000;
            4: return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst_n_i = 0; flush_i = 0; out_ready_i = 1;
        bundle(4'd0, 2'd0, 2'd1, 64'h40, 64'd3, 64'd0, 64'd4, 0, 3'd0);
        model_reset();

        // Reset held with a valid bundle offered: nothing may emerge.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            check("rst.out_valid", 64'(out_valid_o), 64'd0);
            check("rst.redirect",  64'(redirect_o),  64'd0);
            check("rst.misalign",  64'(misalign_o),  64'd0);
            check("rst.result",    result_o,         64'd0);
        end
        rst_n_i = 1;
        cyc("first_fire");
        check("first_fire.valid_const", 64'(out_valid_o), 64'd1);

        // ADD with negative immediate.
        bundle(4'd0, 2'd0, 2'd1, 64'h0, 64'd5, 64'd0, -64'sd7, 0, 3'd0);
        cyc("add");
        check("add.const", result_o, 64'hFFFF_FFFF_FFFF_FFFE);

        // SUBW 0-1 and SRAW of 0x8000_0000 by 4.
        bundle(4'd12, 2'd0, 2'd0, 64'h0, 64'd0, 64'd1, 64'd0, 0, 3'd0);
        cyc("subw");
        check("subw.const", result_o, 64'hFFFF_FFFF_FFFF_FFFF);
        bundle(4'd15, 2'd0, 2'd0, 64'h0, 64'h8000_0000, 64'd4, 64'd0, 0, 3'd0);
        cyc("sraw");
        check("sraw.const", result_o, 64'hFFFF_FFFF_F800_0000);

        // BLTU taken; BGEU with the same operands not taken; pulse lasts one cycle.
        bundle(4'd0, 2'd1, 2'd1, 64'h100, 64'd1, '1, 64'h20, 1, 3'b110);
        cyc("bltu");
        check("bltu.redirect", 64'(redirect_o), 64'd1);
        check("bltu.target",   redirect_pc_o,   64'h120);
        bundle(4'd0, 2'd1, 2'd1, 64'h100, 64'd1, '1, 64'h20, 1, 3'b111);
        cyc("bgeu");
        check("bgeu.redirect", 64'(redirect_o), 64'd0);
        bundle(4'd0, 2'd1, 2'd1, 64'h100, 64'd1, '1, 64'h20, 1, 3'b101);
        cyc("bge");

        // JALR to an odd address: bit0 cleared, bit1 flags misalignment.
        bundle(4'd0, 2'd1, 2'd2, 64'h200, 64'h1003, 64'd0, 64'd0, 3, 3'd0);
        cyc("jalr");
        check("jalr.target",   redirect_pc_o,   64'h1002);
        check("jalr.misalign", 64'(misalign_o), 64'd1);
        check("jalr.result",   result_o,        64'h204);

        // Stall: one entry loaded, then four cycles of backpressure with a new bundle waiting.
        out_ready_i = 0;
        bundle(4'd4, 2'd0, 2'd0, 64'h0, 64'hF0F0, 64'h0FF0, 64'd0, 0, 3'd0);
        cyc("stall_load");
        held = result_o;
        bundle(4'd0, 2'd0, 2'd0, 64'h0, 64'd1, 64'd2, 64'd0, 2, 3'd0);
        for (int i = 0; i < 4; i++) begin
            cyc("stall");
            check("stall.held", result_o, held);
            check("stall.no_redirect", 64'(redirect_o), 64'd0);
        end
        flush_i = 1;
        cyc("flush");
        check("flush.valid", 64'(out_valid_o), 64'd0);
        flush_i = 0;
        out_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            bundle(4'd0, 2'd0, 2'd1, 64'h0, 64'(i), 64'd0, 64'd10, 0, 3'd0);
            cyc("b2b");
            check("b2b.result", result_o, 64'(i + 10));
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            bundle(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   rand_val(), rand_val(), rand_val(), rand_val(),
                   $urandom_range(0, 3), 3'($urandom_range(0, 7)));
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 15) == 0);
            mem_rd_i    = 1'($urandom);
            mem_wr_i    = 1'($urandom);
            rd_i        = 5'($urandom);
            rd_wen_i    = 1'($urandom);
            cyc("rand");
        end

        // Asynchronous reset with an entry in flight clears outputs immediately.
        flush_i = 0; out_ready_i = 0;
        bundle(4'd0, 2'd0, 2'd1, 64'h0, 64'd7, 64'd0, 64'd7, 2, 3'd0);
        cyc("pre_reset");
        #2;
        rst_n_i = 0;
        #1;
        check("async_rst.valid",    64'(out_valid_o), 64'd0);
        check("async_rst.redirect", 64'(redirect_o),  64'd0);
        check("async_rst.result",   result_o,         64'd0);
        model_reset();
        @(posedge clk_i); #1;
        rst_n_i = 1;
        in_valid_i = 0;
        cyc("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
